// File: rtl/lcd_reader.sv
// ---------------------------------------------------------------------------
// lcd_reader
//
// Performs HD44780-style 4-bit read transactions (RW=1) on a character LCD
// bus. It does either a single status read (BF/AC) or a data read, and
// returns the assembled byte. An optional busy-poll mode repeats status
// reads until the busy flag clears or POLL_MAX reads have been made.
//
// The block sits beside the write controller on the shared LCD pins. The
// top level muxes LCD_E/LCD_RS/LCD_RW and uses sf_d_oe to tristate the
// FPGA drivers on sf_d.
//
// Parameters
//   T_SU      RS/RW setup cycles before E rises
//   T_EH      E-high cycles per nibble
//   T_SAMPLE  0-based E-high cycle whose closing edge registers sf_d_in (< T_EH)
//   T_GAP     E-low cycles between nibbles and between repeated polls
//   T_RW_HOLD cycles RW stays high after the final E fall
//   POLL_MAX  maximum status reads per poll transaction
//
// Ports
//   CLK        system clock
//   RST        synchronous, active-high reset
//   START      begin a transaction (sampled only in IDLE)
//   RS_SEL     0 = status read, 1 = data read
//   POLL       with RS_SEL=0, repeat reads while BF=1
//   sf_d_in    LCD data pins DB7..DB4
//   LCD_E      enable strobe
//   LCD_RS     register select
//   LCD_RW     1 = read
//   sf_d_oe    1 = FPGA may drive sf_d
//   DATA       last byte read, {first nibble, second nibble}
//   BUSY_FLAG  DATA[7]
//   ADDR       DATA[6:0]
//   DONE       one-cycle completion pulse
//   BUSY       high while a transaction is in flight (excluding the DONE cycle)
//   TIMEOUT    poll ran out of reads with BF still set; cleared on next START
// ---------------------------------------------------------------------------
module lcd_reader #(
   parameter int T_SU      = 2,
   parameter int T_EH      = 12,
   parameter int T_SAMPLE  = 10,
   parameter int T_GAP     = 50,
   parameter int T_RW_HOLD = 2,
   parameter int POLL_MAX  = 4096
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       RS_SEL,
   input  logic       POLL,
   input  logic [3:0] sf_d_in,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       sf_d_oe,
   output logic [7:0] DATA,
   output logic       BUSY_FLAG,
   output logic [6:0] ADDR,
   output logic       DONE,
   output logic       BUSY,
   output logic       TIMEOUT
);

   // Phase counter must hold the longest phase length minus one.
   localparam int MAX_A = (T_SU > T_EH) ? T_SU : T_EH;
   localparam int MAX_B = (T_GAP > T_RW_HOLD) ? T_GAP : T_RW_HOLD;
   localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
   // Read counter must be able to reach POLL_MAX itself.
   localparam int RCW   = $clog2(POLL_MAX + 1);

   localparam logic [CW-1:0]  SU_LAST   = CW'(T_SU - 1);
   localparam logic [CW-1:0]  EH_LAST   = CW'(T_EH - 1);
   localparam logic [CW-1:0]  GAP_LAST  = CW'(T_GAP - 1);
   localparam logic [CW-1:0]  HOLD_LAST = CW'(T_RW_HOLD - 1);
   localparam logic [CW-1:0]  SAMPLE_AT = CW'(T_SAMPLE);
   localparam logic [RCW-1:0] READS_MAX = RCW'(POLL_MAX);

   typedef enum logic [3:0] {
      S_IDLE,
      S_TURN,
      S_SETUP,
      S_E_HI1,
      S_GAP1,
      S_E_HI2,
      S_PGAP,
      S_HOLD,
      S_RELEASE
   } state_t;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [RCW-1:0]   reads_q, reads_d;
   logic             rs_lat_q, rs_lat_d;
   logic             poll_lat_q, poll_lat_d;
   logic [3:0]       hi_q, hi_d;
   logic [3:0]       lo_q, lo_d;
   logic             to_pend_q, to_pend_d;

   // Registered outputs
   logic             e_q, e_d;
   logic             rs_q, rs_d;
   logic             rw_q, rw_d;
   logic             oe_q, oe_d;
   logic [7:0]       data_q, data_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;

   // Helpers for the E_HI2 exit decision
   logic [RCW-1:0]   reads_inc;
   logic             still_busy;

   assign reads_inc  = reads_q + RCW'(1);
   // Only a polled status read whose high nibble shows BF=1 can repeat.
   assign still_busy = poll_lat_q & ~rs_lat_q & hi_q[3];

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      reads_d    = reads_q;
      rs_lat_d   = rs_lat_q;
      poll_lat_d = poll_lat_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      to_pend_d  = to_pend_q;
      data_d     = data_q;
      done_d     = 1'b0;
      timeout_d  = timeout_q;

      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               rs_lat_d   = RS_SEL;
               poll_lat_d = POLL;
               reads_d    = '0;
               to_pend_d  = 1'b0;
               timeout_d  = 1'b0;
               cnt_d      = '0;
               state_d    = S_TURN;
            end
         end

         // One cycle with the FPGA drivers off and RW still low, so the
         // LCD never starts driving while we are.
         S_TURN: begin
            cnt_d   = '0;
            state_d = S_SETUP;
         end

         S_SETUP: begin
            if (cnt_q == SU_LAST) begin
               cnt_d   = '0;
               state_d = S_E_HI1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_E_HI1: begin
            if (cnt_q == SAMPLE_AT) begin
               hi_d = sf_d_in;
            end
            if (cnt_q == EH_LAST) begin
               cnt_d   = '0;
               state_d = S_GAP1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_GAP1: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_E_HI2;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_E_HI2: begin
            if (cnt_q == SAMPLE_AT) begin
               lo_d = sf_d_in;
            end
            if (cnt_q == EH_LAST) begin
               cnt_d   = '0;
               reads_d = reads_inc;
               if (still_busy && (reads_inc < READS_MAX)) begin
                  state_d = S_PGAP;
               end else begin
                  // Out of reads with BF still set: flag it, reported with DONE.
                  if (still_busy) begin
                     to_pend_d = 1'b1;
                  end
                  state_d = S_HOLD;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // Gap between polls keeps RW high; the bus stays with the LCD.
         S_PGAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_E_HI1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // RW drops but drivers stay off one more cycle before IDLE
         // re-enables them. The byte is published only here, so an
         // interrupted read never reaches DATA.
         S_RELEASE: begin
            cnt_d     = '0;
            data_d    = {hi_q, lo_q};
            done_d    = 1'b1;
            timeout_d = to_pend_q;
            state_d   = S_IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Pin values are decoded from the next state so that the flops present
   // them in the same cycle the state register enters that state.
   always_comb begin
      e_d    = (state_d == S_E_HI1) || (state_d == S_E_HI2);
      rw_d   = (state_d == S_SETUP) || (state_d == S_E_HI1) ||
               (state_d == S_GAP1)  || (state_d == S_E_HI2) ||
               (state_d == S_PGAP)  || (state_d == S_HOLD);
      rs_d   = rw_d & rs_lat_d;
      oe_d   = (state_d == S_IDLE);
      busy_d = (state_d != S_IDLE);
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         reads_q    <= '0;
         rs_lat_q   <= 1'b0;
         poll_lat_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         to_pend_q  <= 1'b0;
         e_q        <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         oe_q       <= 1'b0;
         data_q     <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         reads_q    <= reads_d;
         rs_lat_q   <= rs_lat_d;
         poll_lat_q <= poll_lat_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         to_pend_q  <= to_pend_d;
         e_q        <= e_d;
         rs_q       <= rs_d;
         rw_q       <= rw_d;
         oe_q       <= oe_d;
         data_q     <= data_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
      end
   end

   assign LCD_E     = e_q;
   assign LCD_RS    = rs_q;
   assign LCD_RW    = rw_q;
   assign sf_d_oe   = oe_q;
   assign DATA      = data_q;
   assign BUSY_FLAG = data_q[7];
   assign ADDR      = data_q[6:0];
   assign DONE      = done_q;
   assign BUSY      = busy_q;
   assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_lcd_reader.sv
// ---------------------------------------------------------------------------
// tb_lcd_reader
//
// Directed bench for lcd_reader. An LCD model drives sf_d_in from a nibble
// table, advancing one entry on each falling edge of LCD_E. Each transaction
// is run cycle by cycle (cycle 0 = START accepted) while timing features of
// E/RW/RS/BUSY/DONE are recorded, then compared with hand-computed values.
// POLL_MAX is set to 4 so the timeout case stays short.
// ---------------------------------------------------------------------------
module tb_lcd_reader;

   logic       clk = 1'b0;
   logic       RST;
   logic       START;
   logic       RS_SEL;
   logic       POLL;
   logic [3:0] sf_d_in;
   logic       LCD_E, LCD_RS, LCD_RW, sf_d_oe;
   logic [7:0] DATA;
   logic       BUSY_FLAG;
   logic [6:0] ADDR;
   logic       DONE, BUSY, TIMEOUT;

   lcd_reader #(
      .T_SU(2), .T_EH(12), .T_SAMPLE(10), .T_GAP(50), .T_RW_HOLD(2), .POLL_MAX(4)
   ) dut (
      .CLK(clk), .RST(RST), .START(START), .RS_SEL(RS_SEL), .POLL(POLL),
      .sf_d_in(sf_d_in), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .sf_d_oe(sf_d_oe), .DATA(DATA), .BUSY_FLAG(BUSY_FLAG), .ADDR(ADDR),
      .DONE(DONE), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // LCD model
   logic [3:0] nib [0:15];
   int         efalls = 0;
   int         base = 0;
   logic       e_d1 = 1'b0;
   logic [3:0] nidx;
   always @(negedge clk) begin
      if (e_d1 && !LCD_E) efalls = efalls + 1;
      e_d1 = LCD_E;
   end
   assign nidx    = 4'(efalls - base);
   assign sf_d_in = nib[nidx];

   // Bus contention monitor
   int contention = 0;
   always @(negedge clk) if (sf_d_oe && LCD_RW) contention = contention + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Per-transaction observations
   int   e_cnt, e_first, e_last, e_rise;
   int   rw_cnt, rw_first, rw_last;
   int   rs_cnt, rs_first, rs_last;
   int   busy_cnt, done_cnt, done1, done2;
   logic [7:0] data_at_d1;
   logic to_at1, oe_at82, busy_at82, rw_at39;
   logic e_after, rw_after, oe_after, busy_after, oe_rel0, oe_rel1;

   task automatic run(input logic rs, input logic poll, input int p1, input int p2,
                      input int rst_at, input int rst_len, input int n_done, input int limit);
      int   r;
      int   t0;
      logic e_prev;
      logic rw_prev;
      @(negedge clk);
      base = efalls; t0 = cyc;
      START = 1'b1; RS_SEL = rs; POLL = poll;
      e_cnt = 0; e_first = -1; e_last = -1; e_rise = 0;
      rw_cnt = 0; rw_first = -1; rw_last = -1;
      rs_cnt = 0; rs_first = -1; rs_last = -1;
      busy_cnt = 0; done_cnt = 0; done1 = -1; done2 = -1; data_at_d1 = 8'hxx;
      e_prev = 1'b0; rw_prev = 1'b0;
      r = 0;
      while (r < limit && done_cnt < n_done) begin
         @(negedge clk);
         r = cyc - t0;
         if (LCD_E) begin
            e_cnt++;
            if (e_first < 0) e_first = r;
            e_last = r;
            if (!e_prev) e_rise++;
         end
         e_prev = LCD_E;
         if (LCD_RW) begin
            rw_cnt++;
            if (rw_first < 0) rw_first = r;
            rw_last = r;
         end
         rw_prev = LCD_RW;
         if (LCD_RS) begin
            rs_cnt++;
            if (rs_first < 0) rs_first = r;
            rs_last = r;
         end
         if (BUSY) busy_cnt++;
         if (DONE) begin
            done_cnt++;
            if (done_cnt == 1) begin done1 = r; data_at_d1 = DATA; end
            else done2 = r;
         end
         if (r == 1) to_at1 = TIMEOUT;
         if (r == 82) begin oe_at82 = sf_d_oe; busy_at82 = BUSY; end
         if (r == 39) rw_at39 = LCD_RW;
         if (r == 41) begin e_after = LCD_E; rw_after = LCD_RW; oe_after = sf_d_oe; busy_after = BUSY; end
         if (r == 43) oe_rel0 = sf_d_oe;
         if (r == 44) oe_rel1 = sf_d_oe;
         START = (r == p1) || (r == p2);
         RST   = (rst_at >= 0) && (r >= rst_at) && (r < rst_at + rst_len);
      end
      START = 1'b0;
      RST   = 1'b0;
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; RS_SEL = 1'b0; POLL = 1'b0;
      for (int i = 0; i < 16; i++) nib[i] = 4'h0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("rst_e", LCD_E, 0);
      chk("rst_rw", LCD_RW, 0);
      chk("rst_rs", LCD_RS, 0);
      chk("rst_oe", sf_d_oe, 0);
      chk("rst_data", DATA, 0);
      chk("rst_done", DONE, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_timeout", TIMEOUT, 0);
      RST = 1'b0;
      @(negedge clk);
      chk("oe_after_rst", sf_d_oe, 1);
      $display("reset: done");

      // ---- mid-transaction reset at cycle 40 ----
      nib[0] = 4'h9; nib[1] = 4'h9;
      run(1'b0, 1'b0, -1, -1, 40, 3, 1, 60);
      chk("mr_rw_before", rw_at39, 1);
      chk("mr_e", e_after, 0);
      chk("mr_rw", rw_after, 0);
      chk("mr_oe", oe_after, 0);
      chk("mr_busy", busy_after, 0);
      chk("mr_oe_in_rst", oe_rel0, 0);
      chk("mr_oe_release", oe_rel1, 1);
      chk("mr_no_done", done_cnt, 0);
      chk("mr_data", DATA, 8'h00);
      $display("txn mid-reset: rst@40 done_cnt=%0d data=0x%02h", done_cnt, DATA);

      // ---- status read 0x0/0x5 ----
      nib[0] = 4'h0; nib[1] = 4'h5;
      run(1'b0, 1'b0, -1, -1, -1, 0, 1, 200);
      chk("st_done_cyc", done1, 81);
      chk("st_data", DATA, 8'h05);
      chk("st_bf", BUSY_FLAG, 0);
      chk("st_addr", ADDR, 7'h05);
      chk("st_rs_cnt", rs_cnt, 0);
      chk("st_e_first", e_first, 4);
      chk("st_e_last", e_last, 77);
      chk("st_e_cnt", e_cnt, 24);
      chk("st_e_rise", e_rise, 2);
      chk("st_rw_first", rw_first, 2);
      chk("st_rw_last", rw_last, 79);
      chk("st_rw_cnt", rw_cnt, 78);
      chk("st_busy_cnt", busy_cnt, 80);
      @(negedge clk);
      chk("st_done_pulse", DONE, 0);
      chk("st_data_hold", DATA, 8'h05);
      $display("txn status: done@%0d data=0x%02h", done1, DATA);

      // ---- data read 0x4/0x1 ----
      nib[0] = 4'h4; nib[1] = 4'h1;
      run(1'b1, 1'b0, -1, -1, -1, 0, 1, 200);
      chk("dr_done_cyc", done1, 81);
      chk("dr_data", DATA, 8'h41);
      chk("dr_rs_first", rs_first, 2);
      chk("dr_rs_last", rs_last, 79);
      chk("dr_rs_cnt", rs_cnt, 78);
      $display("txn data: done@%0d data=0x%02h", done1, DATA);

      // ---- poll, BF=1 three times then 0x0/0x3 ----
      nib[0] = 4'h8; nib[1] = 4'h0; nib[2] = 4'h8; nib[3] = 4'h0;
      nib[4] = 4'h8; nib[5] = 4'h0; nib[6] = 4'h0; nib[7] = 4'h3;
      run(1'b0, 1'b1, -1, -1, -1, 0, 1, 700);
      chk("pl_done_cyc", done1, 453);
      chk("pl_data", DATA, 8'h03);
      chk("pl_timeout", TIMEOUT, 0);
      chk("pl_rw_first", rw_first, 2);
      chk("pl_rw_last", rw_last, 451);
      chk("pl_rw_cnt", rw_cnt, 450);
      chk("pl_e_rise", e_rise, 8);
      $display("txn poll: done@%0d data=0x%02h timeout=%0b", done1, DATA, TIMEOUT);

      // ---- poll with BF stuck, POLL_MAX=4 ----
      for (int i = 0; i < 16; i += 2) begin nib[i] = 4'h8; nib[i+1] = 4'h0; end
      run(1'b0, 1'b1, -1, -1, -1, 0, 1, 700);
      chk("to_done_cyc", done1, 453);
      chk("to_e_rise", e_rise, 8);
      chk("to_timeout", TIMEOUT, 1);
      chk("to_data", DATA, 8'h80);
      chk("to_bf", BUSY_FLAG, 1);
      chk("to_addr", ADDR, 7'h00);
      $display("txn poll-timeout: done@%0d data=0x%02h timeout=%0b", done1, DATA, TIMEOUT);

      // ---- next START clears TIMEOUT ----
      nib[0] = 4'h2; nib[1] = 4'hA;
      run(1'b0, 1'b0, -1, -1, -1, 0, 1, 200);
      chk("tc_timeout_c1", to_at1, 0);
      chk("tc_timeout_end", TIMEOUT, 0);
      chk("tc_data", DATA, 8'h2A);
      chk("tc_done_cyc", done1, 81);
      $display("txn timeout-clear: done@%0d data=0x%02h", done1, DATA);

      // ---- START at 30 (ignored) and 81 (back-to-back) ----
      nib[0] = 4'h6; nib[1] = 4'h7; nib[2] = 4'h1; nib[3] = 4'h2;
      run(1'b0, 1'b0, 30, 81, -1, 0, 2, 400);
      chk("bb_done1", done1, 81);
      chk("bb_data1", data_at_d1, 8'h67);
      chk("bb_oe82", oe_at82, 0);
      chk("bb_busy82", busy_at82, 1);
      chk("bb_done2", done2, 162);
      chk("bb_data2", DATA, 8'h12);
      chk("bb_e_rise", e_rise, 4);
      $display("txn back-to-back: done@%0d,%0d data=0x%02h", done1, done2, DATA);

      chk("contention", contention, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
